mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs (control, ALU result, store data, destination register). Runs loads/stores against an external data memory over a req/ack handshake and stalls the pipeline while an access is outstanding. Registers the results toward writeback.

---
 rtl/mem_wb_stage_if.sv | 21 ++
 rtl/mem_wb_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_wb_stage_if;
    localparam int unsigned DATA_W = 32;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage and MEM/WB pipeline register; runs loads/stores over a
// req/ack bus, stalls the upstream pipe while an access is outstanding, aborts on timeout.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [4:0]            WriteRegM,
    input  logic [31:0]           AluOutM,
    input  logic [31:0]           WriteDataM,
    mem_wb_stage_if.master        mem_bus,
    output logic                  StallM,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic [4:0]            WriteRegW,
    output logic [31:0]           ReadDataW,
    output logic [31:0]           AluOutW,
    output logic                  AlignErrW,
    output logic                  BusErrW
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    typedef enum logic [2:0] {WB_BUBBLE, WB_PASS, WB_ALIGN, WB_ACK, WB_BUSERR} wb_op_t;

    state_t              r_state;
    state_t              w_state_nxt;
    wb_op_t              w_wb_op;
    logic                w_access;
    logic                w_misaligned;
    logic                w_launch;
    logic                w_cnt_inc;
    logic                w_ack;
    logic                w_abort;

    logic [CNT_W-1:0]    r_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_regwrite_w;
    logic                r_memtoreg_w;
    logic [REG_W-1:0]    r_writereg_w;
    logic [DATA_W-1:0]   r_readdata_w;
    logic [DATA_W-1:0]   r_aluout_w;
    logic                r_alignerr_w;
    logic                r_buserr_w;

    assign w_access     = MemReadM | MemWriteM;
    assign w_misaligned = w_access & (AluOutM[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, stall and MEM/WB action decode
    always_comb begin
        w_state_nxt = r_state;
        w_wb_op     = WB_BUBBLE;
        w_launch    = 1'b0;
        w_cnt_inc   = 1'b0;
        w_ack       = 1'b0;
        w_abort     = 1'b0;
        StallM      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && !w_misaligned) begin
                    StallM      = 1'b1;
                    w_launch    = 1'b1;
                    w_state_nxt = S_WAIT;
                end else if (w_misaligned) begin
                    w_wb_op = WB_ALIGN;
                end else begin
                    w_wb_op = WB_PASS;
                end
            end
            S_WAIT: begin
                if (mem_bus.mem_ack) begin
                    w_ack       = 1'b1;
                    w_wb_op     = WB_ACK;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != CNT_W'(TIMEOUT)) begin
                    StallM    = 1'b1;
                    w_cnt_inc = 1'b1;
                end else begin
                    w_abort     = 1'b1;
                    w_wb_op     = WB_BUSERR;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory request registers and wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_launch) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= MemWriteM;
                r_mem_addr  <= AluOutM;
                r_mem_wdata <= WriteDataM;
                r_cnt       <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_ack) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end
            if (w_abort) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    // MEM/WB register; a bubble clears control and flags but holds the data fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
            r_writereg_w <= '0;
            r_readdata_w <= '0;
            r_aluout_w   <= '0;
            r_alignerr_w <= 1'b0;
            r_buserr_w   <= 1'b0;
        end else begin
            case (w_wb_op)
                WB_PASS, WB_ACK: begin
                    r_regwrite_w <= RegWriteM;
                    r_memtoreg_w <= MemtoRegM;
                end
                default: begin
                    r_regwrite_w <= 1'b0;
                    r_memtoreg_w <= 1'b0;
                end
            endcase
            if (w_wb_op != WB_BUBBLE) begin
                r_writereg_w <= WriteRegM;
                r_aluout_w   <= AluOutM;
                r_readdata_w <= (w_wb_op == WB_ACK && MemReadM) ? mem_bus.mem_rdata : '0;
            end
            r_alignerr_w <= (w_wb_op == WB_ALIGN);
            r_buserr_w   <= (w_wb_op == WB_BUSERR);
        end
    end

    assign mem_bus.mem_req   = r_mem_req;
    assign mem_bus.mem_we    = r_mem_we;
    assign mem_bus.mem_addr  = r_mem_addr;
    assign mem_bus.mem_wdata = r_mem_wdata;

    assign RegWriteW = r_regwrite_w;
    assign MemtoRegW = r_memtoreg_w;
    assign WriteRegW = r_writereg_w;
    assign ReadDataW = r_readdata_w;
    assign AluOutW   = r_aluout_w;
    assign AlignErrW = r_alignerr_w;
    assign BusErrW   = r_buserr_w;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_wb_stage;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteM, MemtoRegM, MemReadM, MemWriteM;
    logic [4:0]  WriteRegM;
    logic [31:0] AluOutM, WriteDataM;
    logic        StallM, RegWriteW, MemtoRegW, AlignErrW, BusErrW;
    logic [4:0]  WriteRegW;
    logic [31:0] ReadDataW, AluOutW;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if u_bus();

    mem_wb_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .WriteRegM  (WriteRegM),
        .AluOutM    (AluOutM),
        .WriteDataM (WriteDataM),
        .mem_bus    (u_bus.master),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .WriteRegW  (WriteRegW),
        .ReadDataW  (ReadDataW),
        .AluOutW    (AluOutW),
        .AlignErrW  (AlignErrW),
        .BusErrW    (BusErrW)
    );

    typedef struct {
        int          stalls;
        int          reqs;
        logic        rw;
        logic        mtr;
        logic        ae;
        logic        be;
        logic [31:0] rdata;
    } exp_t;

    // Observations collected while a transaction runs
    int          o_stalls, o_reqs, o_bub_bad, o_unstable;
    logic        o_hung, o_we, o_req_after;
    logic [31:0] o_addr, o_wdata;

    // Transaction-level expectation: ack after d wait cycles (d<0: never)
    function automatic exp_t model(input logic rd, input logic wr, input logic rw, input logic mtr,
                                   input logic [31:0] addr, input logic [31:0] rdata, input int d);
        exp_t e;
        logic acc;
        acc = rd | wr;
        e.stalls = 0; e.reqs = 0; e.rw = rw; e.mtr = mtr; e.ae = 1'b0; e.be = 1'b0; e.rdata = 32'h0;
        if (acc && addr[1:0] != 2'b00) begin
            e.rw = 1'b0; e.mtr = 1'b0; e.ae = 1'b1;
        end else if (acc && d >= 0 && d <= int'(TO)) begin
            e.stalls = d + 1; e.reqs = d + 1;
            if (rd) e.rdata = rdata;
        end else if (acc) begin
            e.stalls = int'(TO) + 1; e.reqs = int'(TO) + 1;
            e.rw = 1'b0; e.mtr = 1'b0; e.be = 1'b1;
        end
        return e;
    endfunction

    task automatic set_nop();
        RegWriteM = 1'b0; MemtoRegM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
        WriteRegM = 5'd0; AluOutM = 32'h0; WriteDataM = 32'h0;
    endtask

    // Present one instruction, act as memory, run until StallM drops; ends at posedge+1
    task automatic drive_txn(input logic rd, input logic wr, input logic rw, input logic mtr,
                             input logic [4:0] wreg, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int d);
        int   wi;
        logic st;
        logic done;
        RegWriteM = rw; MemtoRegM = mtr; MemReadM = rd; MemWriteM = wr;
        WriteRegM = wreg; AluOutM = addr; WriteDataM = wdata;
        o_stalls = 0; o_bub_bad = 0; o_unstable = 0; wi = 0; done = 1'b0;
        o_we = 1'b0; o_addr = 32'h0; o_wdata = 32'h0;
        for (int c = 0; c < 3 * int'(TO) + 20; c++) begin
            u_bus.mem_ack   = u_bus.mem_req && (wi == d);
            u_bus.mem_rdata = u_bus.mem_ack ? rdata : $urandom;
            #1;
            if (u_bus.mem_req) begin
                if (wi == 0) begin
                    o_addr = u_bus.mem_addr; o_we = u_bus.mem_we; o_wdata = u_bus.mem_wdata;
                end else if (o_addr !== u_bus.mem_addr || o_we !== u_bus.mem_we || o_wdata !== u_bus.mem_wdata) begin
                    o_unstable++;
                end
                if (RegWriteW || MemtoRegW || AlignErrW || BusErrW) o_bub_bad++;
                wi++;
            end
            st = StallM;
            if (st) o_stalls++;
            @(posedge clk); #1;
            u_bus.mem_ack = 1'b0;
            if (!st) begin
                done = 1'b1;
                break;
            end
        end
        o_hung      = !done;
        o_reqs      = wi;
        o_req_after = u_bus.mem_req;
        set_nop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_nop();
        u_bus.mem_ack = 1'b0; u_bus.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (u_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", u_bus.mem_req); end
        n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", StallM); end
        n_checks++; if ({RegWriteW, MemtoRegW, AlignErrW, BusErrW} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b exp 0000", {RegWriteW, MemtoRegW, AlignErrW, BusErrW}); end
        n_checks++; if ({WriteRegW, ReadDataW, AluOutW} !== 69'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", {WriteRegW, ReadDataW, AluOutW}); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_op();
        drive_txn(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0000_0010, 32'h0, 32'h5555_AAAA, -1);
        n_checks++; if (o_stalls !== 0) begin n_fail++; $display("FAIL alu_stall: got %0d exp 0", o_stalls); end
        n_checks++; if (RegWriteW !== 1'b1) begin n_fail++; $display("FAIL alu_regw: got %b exp 1", RegWriteW); end
        n_checks++; if (WriteRegW !== 5'd8) begin n_fail++; $display("FAIL alu_wreg: got %0d exp 8", WriteRegW); end
        n_checks++; if (AluOutW !== 32'h10) begin n_fail++; $display("FAIL alu_aluout: got %h exp 10", AluOutW); end
        n_checks++; if (ReadDataW !== 32'h0) begin n_fail++; $display("FAIL alu_rdata: got %h exp 0", ReadDataW); end
    endtask

    task automatic test_load();
        drive_txn(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
        n_checks++; if (o_reqs !== 3) begin n_fail++; $display("FAIL load_req_cycles: got %0d exp 3", o_reqs); end
        n_checks++; if (o_stalls !== 3) begin n_fail++; $display("FAIL load_stall: got %0d exp 3", o_stalls); end
        n_checks++; if (o_addr !== 32'h100 || o_we !== 1'b0) begin n_fail++; $display("FAIL load_bus: got addr %h we %b exp 100/0", o_addr, o_we); end
        n_checks++; if (ReadDataW !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h exp deadbeef", ReadDataW); end
        n_checks++; if ({RegWriteW, MemtoRegW} !== 2'b11) begin n_fail++; $display("FAIL load_ctl: got %b exp 11", {RegWriteW, MemtoRegW}); end
        n_checks++; if (o_req_after !== 1'b0 || o_bub_bad !== 0 || o_unstable !== 0) begin n_fail++; $display("FAIL load_protocol: req_after %b bubble_bad %0d unstable %0d exp 0/0/0", o_req_after, o_bub_bad, o_unstable); end
    endtask

    task automatic test_store();
        drive_txn(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0204, 32'h1234_5678, 32'hFFFF_FFFF, 0);
        n_checks++; if (o_we !== 1'b1 || o_wdata !== 32'h1234_5678 || o_addr !== 32'h204) begin n_fail++; $display("FAIL store_bus: got we %b wdata %h addr %h exp 1/12345678/204", o_we, o_wdata, o_addr); end
        n_checks++; if (o_stalls !== 1) begin n_fail++; $display("FAIL store_stall: got %0d exp 1", o_stalls); end
        n_checks++; if (RegWriteW !== 1'b0 || ReadDataW !== 32'h0) begin n_fail++; $display("FAIL store_wb: got regw %b rdata %h exp 0/0", RegWriteW, ReadDataW); end
    endtask

    task automatic test_misaligned();
        drive_txn(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0102, 32'h0, 32'h1111_1111, 0);
        n_checks++; if (o_reqs !== 0 || o_stalls !== 0) begin n_fail++; $display("FAIL align_noreq: got reqs %0d stalls %0d exp 0/0", o_reqs, o_stalls); end
        n_checks++; if ({AlignErrW, BusErrW, RegWriteW, MemtoRegW} !== 4'b1000) begin n_fail++; $display("FAIL align_flags: got %b exp 1000", {AlignErrW, BusErrW, RegWriteW, MemtoRegW}); end
        drive_txn(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h0000_0040, 32'h0, 32'h0, -1);
        n_checks++; if (AlignErrW !== 1'b0) begin n_fail++; $display("FAIL align_pulse: got %b exp 0", AlignErrW); end
    endtask

    task automatic test_timeout();
        drive_txn(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h0000_0300, 32'h0, 32'h2222_2222, -1);
        n_checks++; if (o_stalls !== int'(TO) + 1) begin n_fail++; $display("FAIL to_stall: got %0d exp %0d", o_stalls, TO + 1); end
        n_checks++; if (o_req_after !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b exp 0", o_req_after); end
        n_checks++; if ({BusErrW, AlignErrW, RegWriteW, MemtoRegW} !== 4'b1000) begin n_fail++; $display("FAIL to_flags: got %b exp 1000", {BusErrW, AlignErrW, RegWriteW, MemtoRegW}); end
        // late ack while idle
        u_bus.mem_ack = 1'b1; u_bus.mem_rdata = 32'hBAD0_BAD0;
        #1;
        n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL late_ack_stall: got %b exp 0", StallM); end
        @(posedge clk); #1;
        u_bus.mem_ack = 1'b0;
        n_checks++; if (u_bus.mem_req !== 1'b0 || BusErrW !== 1'b0 || ReadDataW !== 32'h0) begin n_fail++; $display("FAIL late_ack: got req %b buserr %b rdata %h exp 0/0/0", u_bus.mem_req, BusErrW, ReadDataW); end
        // ack on the very last permitted wait cycle still completes the load
        drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 5'd13, 32'h0000_0304, 32'h0, 32'h3333_4444, int'(TO));
        n_checks++; if (BusErrW !== 1'b0 || ReadDataW !== 32'h3333_4444 || RegWriteW !== 1'b1) begin n_fail++; $display("FAIL to_edge_ack: got buserr %b rdata %h regw %b exp 0/33334444/1", BusErrW, ReadDataW, RegWriteW); end
    endtask

    task automatic test_reset_in_wait();
        RegWriteM = 1'b1; MemtoRegM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0;
        WriteRegM = 5'd7; AluOutM = 32'h0000_0400; WriteDataM = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (u_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rw_req_up: got %b exp 1", u_bus.mem_req); end
        rst_n = 1'b0;
        set_nop();
        @(posedge clk); #1;
        n_checks++; if (u_bus.mem_req !== 1'b0 || StallM !== 1'b0) begin n_fail++; $display("FAIL rw_req: got req %b stall %b exp 0/0", u_bus.mem_req, StallM); end
        n_checks++; if ({RegWriteW, MemtoRegW, WriteRegW, AluOutW, ReadDataW, AlignErrW, BusErrW} !== 73'h0) begin n_fail++; $display("FAIL rw_memwb: got %h exp 0", {RegWriteW, MemtoRegW, WriteRegW, AluOutW, ReadDataW, AlignErrW, BusErrW}); end
        rst_n = 1'b1;
        u_bus.mem_ack = 1'b1; u_bus.mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        u_bus.mem_ack = 1'b0;
        n_checks++; if (u_bus.mem_req !== 1'b0 || ReadDataW !== 32'h0 || RegWriteW !== 1'b0) begin n_fail++; $display("FAIL rw_post_ack: got req %b rdata %h regw %b exp 0/0/0", u_bus.mem_req, ReadDataW, RegWriteW); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic        rd, wr, rw, mtr;
        logic [4:0]  wreg;
        logic [31:0] addr, wdata, rdata;
        int          kind, d;
        for (int t = 0; t < 60; t++) begin
            kind  = int'($urandom_range(0, 2));
            rd    = (kind == 1); wr = (kind == 2);
            rw    = 1'($urandom_range(0, 1)); mtr = 1'($urandom_range(0, 1));
            wreg  = 5'($urandom);
            addr  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            wdata = $urandom; rdata = $urandom;
            d     = int'($urandom_range(0, 7)) - 1;
            e     = model(rd, wr, rw, mtr, addr, rdata, d);
            drive_txn(rd, wr, rw, mtr, wreg, addr, wdata, rdata, d);
            n_checks++; if (o_hung !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_hung: got %b exp 0", t, o_hung); end
            n_checks++; if (o_stalls !== e.stalls) begin n_fail++; $display("FAIL rnd%0d_stall: got %0d exp %0d", t, o_stalls, e.stalls); end
            n_checks++; if (o_reqs !== e.reqs) begin n_fail++; $display("FAIL rnd%0d_req_cycles: got %0d exp %0d", t, o_reqs, e.reqs); end
            n_checks++; if ({RegWriteW, MemtoRegW, AlignErrW, BusErrW} !== {e.rw, e.mtr, e.ae, e.be}) begin n_fail++; $display("FAIL rnd%0d_ctl: got %b exp %b", t, {RegWriteW, MemtoRegW, AlignErrW, BusErrW}, {e.rw, e.mtr, e.ae, e.be}); end
            n_checks++; if (WriteRegW !== wreg || AluOutW !== addr) begin n_fail++; $display("FAIL rnd%0d_pass: got wreg %0d alu %h exp %0d/%h", t, WriteRegW, AluOutW, wreg, addr); end
            n_checks++; if (ReadDataW !== e.rdata) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h exp %h", t, ReadDataW, e.rdata); end
            n_checks++; if (o_bub_bad !== 0 || o_unstable !== 0 || o_req_after !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_protocol: bubble_bad %0d unstable %0d req_after %b exp 0/0/0", t, o_bub_bad, o_unstable, o_req_after); end
            if (e.reqs > 0) begin
                n_checks++; if (o_addr !== addr || o_we !== wr || o_wdata !== wdata) begin n_fail++; $display("FAIL rnd%0d_bus: got %h/%b/%h exp %h/%b/%h", t, o_addr, o_we, o_wdata, addr, wr, wdata); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
